// File: rtl/movement_nxn_pkg.sv
// Shared definitions for the 2048 move engine: direction encodings,
// move-FSM states and default board geometry.
package game_2048_pkg;

    localparam int N_DEF         = 4;
    localparam int W_DEF         = 12;
    localparam int SCORE_W_DEF   = 20;
    localparam int WIN_VALUE_DEF = 2048;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/movement_nxn_if.sv
// Start/done bundle between the direction decoder, the move engine and the
// spawner/board register. The engine is the slave side.
interface movement_nxn_if
    import game_2048_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int W       = W_DEF,
    parameter int SCORE_W = SCORE_W_DEF
);
    logic                          start;
    logic [3:0]                    direction;
    logic [N-1:0][N-1:0][W-1:0]    matrix;
    logic [N-1:0][N-1:0][W-1:0]    moved_matrix;
    logic                          ready;
    logic                          done;
    logic                          changed;
    logic [SCORE_W-1:0]            score_delta;
    logic                          win;

    modport master (
        output start, direction, matrix,
        input  moved_matrix, ready, done, changed, score_delta, win
    );

    modport slave (
        input  start, direction, matrix,
        output moved_matrix, ready, done, changed, score_delta, win
    );
endinterface

// File: rtl/movement_nxn_line_merge.sv
// Combinational slide/merge of one line toward element 0. Zero tiles are
// squeezed out, equal neighbours merge once, and a pair whose sum does not
// fit in W bits is left unmerged.
module line_merge #(
    parameter int N    = 4,
    parameter int W    = 12,
    parameter int LS_W = W + $clog2(N)
) (
    input  logic [N-1:0][W-1:0] line,
    output logic [N-1:0][W-1:0] merged,
    output logic [LS_W-1:0]     line_score,
    output logic                line_changed
);
    // comp carries one spare zero entry so the last tile always has a neighbour
    logic [N:0][W-1:0] comp;
    logic [W:0]        pair_sum;
    logic [W-1:0]      val;
    logic              skip;
    int                cnt;
    int                k;

    // compact, then merge pairs left to right, then zero-fill
    always_comb begin
        comp         = '0;
        cnt          = 0;
        merged       = '0;
        line_score   = '0;
        k            = 0;
        skip         = 1'b0;
        pair_sum     = '0;
        val          = '0;
        for (int i = 0; i < N; i++) begin
            if (line[i] != '0) begin
                for (int p = 0; p < N; p++) begin
                    if (p == cnt) comp[p] = line[i];
                end
                cnt = cnt + 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[i] != '0) begin
                pair_sum = {1'b0, comp[i]} + {1'b0, comp[i+1]};
                if ((comp[i] == comp[i+1]) && !pair_sum[W]) begin
                    val        = pair_sum[W-1:0];
                    line_score = line_score + LS_W'(val);
                    skip       = 1'b1;
                end else begin
                    val = comp[i];
                end
                for (int p = 0; p < N; p++) begin
                    if (p == k) merged[p] = val;
                end
                k = k + 1;
            end
        end
        line_changed = (merged != line);
    end
endmodule

// File: rtl/movement_nxn.sv
// 2048 move engine for an N x N board: captures the board on start, runs one
// line per clock through a shared line_merge, then presents the moved board,
// saturating score, changed and win flags with a one-cycle done pulse.
module movement_nxn
    import game_2048_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int W         = W_DEF,
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int WIN_VALUE = WIN_VALUE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    movement_nxn_if.slave bus
);
    localparam int IDX_W = $clog2(N);
    localparam int LS_W  = W + $clog2(N);
    localparam int SUM_W = ((SCORE_W > LS_W) ? SCORE_W : LS_W) + 1;

    typedef logic [N-1:0][N-1:0][W-1:0] board_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         dir_cap;
    board_t             board_cap;
    board_t             work_board;
    board_t             wb_board;
    logic [SCORE_W-1:0] score_acc, score_nxt;
    logic               changed_acc, changed_nxt;
    logic               win_nxt;
    logic [N-1:0][W-1:0] line_in, line_out;
    logic [LS_W-1:0]    line_score;
    logic               line_changed;
    board_t             moved_r;
    logic [SCORE_W-1:0] score_r;
    logic               changed_r;
    logic               win_r;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] acc,
                                                   input logic [LS_W-1:0]    inc);
        logic [SUM_W-1:0] s;
        s = SUM_W'(acc) + SUM_W'(inc);
        if (s > SUM_W'({SCORE_W{1'b1}})) return {SCORE_W{1'b1}};
        return s[SCORE_W-1:0];
    endfunction

    line_merge #(.N(N), .W(W), .LS_W(LS_W)) u_merge (
        .line        (line_in),
        .merged      (line_out),
        .line_score  (line_score),
        .line_changed(line_changed)
    );

    assign bus.ready        = (state == IDLE);
    assign bus.done         = (state == DONE);
    assign bus.moved_matrix = moved_r;
    assign bus.score_delta  = score_r;
    assign bus.changed      = changed_r;
    assign bus.win          = win_r;

    // next-state: accept only a single-direction request, leave RUN after the last line
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && $onehot(bus.direction)) state_nxt = RUN;
            RUN:     if (idx == IDX_W'(N-1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // pick line idx out of the captured board, element 0 on the destination side
    always_comb begin
        line_in = '0;
        for (int e = 0; e < N; e++) begin
            case (dir_cap)
                DIR_UP:    line_in[e] = board_cap[e][idx];
                DIR_DOWN:  line_in[e] = board_cap[N-1-e][idx];
                DIR_RIGHT: line_in[e] = board_cap[idx][N-1-e];
                default:   line_in[e] = board_cap[idx][e];
            endcase
        end
    end

    // write the merged line back with the same mapping and fold in score/flags
    always_comb begin
        wb_board = work_board;
        for (int e = 0; e < N; e++) begin
            case (dir_cap)
                DIR_UP:    wb_board[e][idx]     = line_out[e];
                DIR_DOWN:  wb_board[N-1-e][idx] = line_out[e];
                DIR_RIGHT: wb_board[idx][N-1-e] = line_out[e];
                default:   wb_board[idx][e]     = line_out[e];
            endcase
        end
        score_nxt   = sat_add(score_acc, line_score);
        changed_nxt = changed_acc | line_changed;
        win_nxt     = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (32'(wb_board[r][c]) >= 32'(WIN_VALUE)) win_nxt = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // capture on accept, accumulate per line in RUN, publish results on the last line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            dir_cap     <= '0;
            board_cap   <= '0;
            work_board  <= '0;
            score_acc   <= '0;
            changed_acc <= 1'b0;
            moved_r     <= '0;
            score_r     <= '0;
            changed_r   <= 1'b0;
            win_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == RUN) begin
                        board_cap   <= bus.matrix;
                        dir_cap     <= bus.direction;
                        idx         <= '0;
                        score_acc   <= '0;
                        changed_acc <= 1'b0;
                        work_board  <= '0;
                    end
                end
                RUN: begin
                    work_board  <= wb_board;
                    score_acc   <= score_nxt;
                    changed_acc <= changed_nxt;
                    idx         <= idx + 1'b1;
                    if (state_nxt == DONE) begin
                        idx       <= '0;
                        moved_r   <= wb_board;
                        score_r   <= score_nxt;
                        changed_r <= changed_nxt;
                        win_r     <= win_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_movement_nxn.sv
// Self-checking bench for movement_nxn: a queue-based move model predicts the
// outputs every cycle; directed boards pin the model with literal values and a
// random phase exercises arbitrary boards, directions and start timing.
module tb_movement_nxn;
    import game_2048_pkg::*;

    localparam int N         = 4;
    localparam int W         = 12;
    localparam int SCORE_W   = 20;
    localparam int WIN_VALUE = 2048;

    typedef logic [N-1:0][N-1:0][W-1:0] board_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    movement_nxn_if #(.N(N), .W(W), .SCORE_W(SCORE_W)) bus ();

    movement_nxn #(.N(N), .W(W), .SCORE_W(SCORE_W), .WIN_VALUE(WIN_VALUE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_board(input string name, input board_t act, input board_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- behavioural model ----------------
    function automatic void map_rc(input logic [3:0] d, input int i, input int e,
                                   output int r, output int c);
        case (d)
            DIR_UP:    begin r = e;     c = i;     end
            DIR_DOWN:  begin r = N-1-e; c = i;     end
            DIR_RIGHT: begin r = i;     c = N-1-e; end
            default:   begin r = i;     c = e;     end
        endcase
    endfunction

    function automatic void model_line(input int in_l[N], output int out_l[N], output longint sc);
        int q[$];
        int res[$];
        int i;
        sc = 0;
        for (int j = 0; j < N; j++) if (in_l[j] != 0) q.push_back(in_l[j]);
        i = 0;
        while (i < q.size()) begin
            if (i + 1 < q.size() && q[i] == q[i+1] && 2 * q[i] <= (1 << W) - 1) begin
                res.push_back(2 * q[i]);
                sc += 2 * q[i];
                i += 2;
            end else begin
                res.push_back(q[i]);
                i += 1;
            end
        end
        for (int j = 0; j < N; j++) out_l[j] = (j < res.size()) ? res[j] : 0;
    endfunction

    function automatic void model_move(input board_t b, input logic [3:0] d, output board_t o,
                                       output longint score, output bit chg, output bit win);
        int li[N];
        int lo[N];
        longint sc;
        int r, c;
        o = '0;
        score = 0;
        for (int i = 0; i < N; i++) begin
            for (int e = 0; e < N; e++) begin
                map_rc(d, i, e, r, c);
                li[e] = int'(b[r][c]);
            end
            model_line(li, lo, sc);
            score += sc;
            for (int e = 0; e < N; e++) begin
                map_rc(d, i, e, r, c);
                o[r][c] = W'(lo[e]);
            end
        end
        if (score > (longint'(1) << SCORE_W) - 1) score = (longint'(1) << SCORE_W) - 1;
        chg = (o != b);
        win = 1'b0;
        for (int rr = 0; rr < N; rr++)
            for (int cc = 0; cc < N; cc++)
                if (int'(o[rr][cc]) >= WIN_VALUE) win = 1'b1;
    endfunction

    // cycles remaining until the engine is idle again; 0 = ready, 1 = done cycle
    int     left = 0;
    board_t p_moved, m_moved;
    longint p_score, m_score;
    bit     p_chg, m_chg, p_win, m_win;

    // model: a valid request costs N busy cycles plus one done cycle
    always @(posedge clk or posedge rst) begin : model_p
        board_t t_o;
        longint t_s;
        bit     t_c, t_w;
        if (rst) begin
            left    <= 0;
            m_moved <= '0;
            m_score <= 0;
            m_chg   <= 1'b0;
            m_win   <= 1'b0;
        end else if (left == 0) begin
            if (bus.start && $countones(bus.direction) == 1) begin
                model_move(bus.matrix, bus.direction, t_o, t_s, t_c, t_w);
                p_moved <= t_o;
                p_score <= t_s;
                p_chg   <= t_c;
                p_win   <= t_w;
                left    <= N + 1;
            end
        end else begin
            left <= left - 1;
            if (left == 2) begin
                m_moved <= p_moved;
                m_score <= p_score;
                m_chg   <= p_chg;
                m_win   <= p_win;
            end
        end
    end

    // compare every cycle away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check("ready", longint'(bus.ready), longint'(left == 0));
            check("done", longint'(bus.done), longint'(left == 1));
            check("changed", longint'(bus.changed), longint'(m_chg));
            check("score", longint'(bus.score_delta), m_score);
            check("win", longint'(bus.win), longint'(m_win));
            check_board("moved", bus.moved_matrix, m_moved);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic board_t mk(input int rows[N][N]);
        board_t b;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b[r][c] = W'(rows[r][c]);
        return b;
    endfunction

    function automatic logic [W-1:0] rand_tile();
        int k;
        k = $urandom_range(0, 7);
        if (k == 7) k = $urandom_range(8, 11);
        return (k == 0) ? '0 : W'(1 << k);
    endfunction

    task automatic do_move(input board_t b, input logic [3:0] d, input bit poke, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) timeout_fail("ready_wait");
        bus.matrix    = b;
        bus.direction = d;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (poke) begin
            bus.start     = 1'b1;
            bus.direction = DIR_DOWN;
            bus.matrix    = ~b;
        end
        lat = 1;
        while (!bus.done && lat < 50) begin
            @(negedge clk);
            lat++;
            if (lat == 3) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        if (lat >= 50) timeout_fail("done_wait");
        lat = lat - 1;
    endtask

    int     rows[N][N];
    board_t b1, b;
    int     lat;

    initial begin
        bus.start     = 1'b0;
        bus.direction = 4'b0000;
        bus.matrix    = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", longint'(bus.ready), 1);
        check("rst_done", longint'(bus.done), 0);
        check("rst_score", longint'(bus.score_delta), 0);
        check("rst_changed", longint'(bus.changed), 0);
        check("rst_win", longint'(bus.win), 0);
        check_board("rst_moved", bus.moved_matrix, '0);
        rst = 1'b0;

        // up move: column 0 {2,4,4,4} -> {2,8,4,0}
        rows = '{'{2, 2, 0, 0}, '{4, 0, 0, 0}, '{4, 0, 0, 0}, '{4, 0, 0, 0}};
        b1 = mk(rows);
        do_move(b1, DIR_UP, 1'b0, lat);
        check("up_lat", lat, N);
        check("up_c0r0", longint'(bus.moved_matrix[0][0]), 2);
        check("up_c0r1", longint'(bus.moved_matrix[1][0]), 8);
        check("up_c0r2", longint'(bus.moved_matrix[2][0]), 4);
        check("up_c0r3", longint'(bus.moved_matrix[3][0]), 0);
        check("up_c1r0", longint'(bus.moved_matrix[0][1]), 2);
        check("up_score", longint'(bus.score_delta), 8);
        check("up_changed", longint'(bus.changed), 1);

        // {2,2,2,2} left -> {4,4,0,0}
        rows = '{'{2, 2, 2, 2}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        do_move(mk(rows), DIR_LEFT, 1'b0, lat);
        check("l4_0", longint'(bus.moved_matrix[0][0]), 4);
        check("l4_1", longint'(bus.moved_matrix[0][1]), 4);
        check("l4_2", longint'(bus.moved_matrix[0][2]), 0);
        check("l4_score", longint'(bus.score_delta), 8);

        // {4,4,8,0} right -> {0,0,8,8}
        rows = '{'{4, 4, 8, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        do_move(mk(rows), DIR_RIGHT, 1'b0, lat);
        check("r_2", longint'(bus.moved_matrix[0][2]), 8);
        check("r_3", longint'(bus.moved_matrix[0][3]), 8);
        check("r_1", longint'(bus.moved_matrix[0][1]), 0);
        check("r_score", longint'(bus.score_delta), 8);

        // no-op move still pulses done
        rows = '{'{2, 4, 8, 16}, '{2, 4, 8, 16}, '{2, 4, 8, 16}, '{2, 4, 8, 16}};
        b = mk(rows);
        do_move(b, DIR_LEFT, 1'b0, lat);
        check_board("noop_board", bus.moved_matrix, b);
        check("noop_changed", longint'(bus.changed), 0);
        check("noop_score", longint'(bus.score_delta), 0);
        check("noop_done", longint'(bus.done), 1);

        // overflowing pair stays unmerged
        rows = '{'{2048, 2048, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        do_move(mk(rows), DIR_LEFT, 1'b0, lat);
        check("ovf_0", longint'(bus.moved_matrix[0][0]), 2048);
        check("ovf_1", longint'(bus.moved_matrix[0][1]), 2048);
        check("ovf_score", longint'(bus.score_delta), 0);
        check("ovf_win", longint'(bus.win), 1);

        // merge reaching the win value
        rows = '{'{1024, 1024, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        do_move(mk(rows), DIR_LEFT, 1'b0, lat);
        check("win_0", longint'(bus.moved_matrix[0][0]), 2048);
        check("win_1", longint'(bus.moved_matrix[0][1]), 0);
        check("win_score", longint'(bus.score_delta), 2048);
        check("win_flag", longint'(bus.win), 1);

        // two direction bits: request ignored
        @(negedge clk);
        bus.direction = 4'b0011;
        bus.start     = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("inv_ready", longint'(bus.ready), 1);
            check("inv_done", longint'(bus.done), 0);
        end
        bus.start = 1'b0;

        // start during RUN is ignored
        rows = '{'{2, 2, 2, 2}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        do_move(mk(rows), DIR_LEFT, 1'b1, lat);
        check("poke_lat", lat, N);
        check("poke_0", longint'(bus.moved_matrix[0][0]), 4);
        check("poke_1", longint'(bus.moved_matrix[0][1]), 4);
        check("poke_score", longint'(bus.score_delta), 8);

        // asynchronous reset two cycles into RUN
        @(negedge clk);
        bus.matrix    = b1;
        bus.direction = DIR_UP;
        bus.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_ready", longint'(bus.ready), 1);
        check("arst_done", longint'(bus.done), 0);
        check("arst_score", longint'(bus.score_delta), 0);
        check_board("arst_moved", bus.moved_matrix, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("arst_nodone", longint'(bus.done), 0);
        end
        do_move(b1, DIR_UP, 1'b0, lat);
        check("arst_lat", lat, N);
        check("arst_c0r1", longint'(bus.moved_matrix[1][0]), 8);
        check("arst_score2", longint'(bus.score_delta), 8);

        // random boards, directions and start timing
        for (int it = 0; it < 800; it++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) bus.direction = 4'($urandom_range(0, 15));
            else                           bus.direction = 4'(1 << $urandom_range(0, 3));
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    bus.matrix[r][c] = rand_tile();
        end
        bus.start = 1'b0;
        repeat (N + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
